// File: rtl/mem_alloc_pool_ctrl.sv
// Free-address pool for the memcached pipeline: circular buffer of chunk addresses with flush/rebuild FSM.
// Optional statistics counters are built when MEM_ALLOC_POOL_STATS_EN is defined.
module mem_alloc_pool_ctrl #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          NUM_CHUNKS  = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          STRIDE_LOG2 = 7
) (
  input  logic                  ACLK,
  input  logic                  Axi_resetn,
  output logic [31:0]           alloc_data,
  output logic                  alloc_valid,
  input  logic                  alloc_ready,
  input  logic [31:0]           reclaim_data,
  input  logic                  reclaim_valid,
  output logic                  reclaim_ready,
  output logic                  reclaim_err,
  input  logic                  flushReq,
  output logic                  flushAck,
  input  logic                  flushDone,
  output logic [DEPTH_LOG2:0]   free_count,
  output logic                  init_busy,
  output logic [31:0]           stats_alloc,
  output logic [31:0]           stats_reclaim,
  output logic [1:0]            fsm_state
);

  // Handshakes: a word moves on a rising edge where valid & ready are both high;
  // valid/ready are driven only from registered state, never from the partner's signal.

  typedef enum logic [1:0] {
    ST_INIT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_FLUSH_ACK  = 2'd2,
    ST_FLUSH_WAIT = 2'd3
  } state_t;

  localparam int          PW        = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] NUM_C   = PW'(NUM_CHUNKS);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_CHUNKS - 1);
  localparam logic [31:0] LINE_MASK = (32'd1 << STRIDE_LOG2) - 32'd1;

  state_t        state, state_next;
  logic [31:0]   mem [2**DEPTH_LOG2];
  logic [PW-1:0] rd_ptr, wr_ptr, count, init_idx;
  logic          alloc_fire, reclaim_fire, reclaim_ok, store;
  logic [31:0]   reclaim_off, init_addr, wr_data;

  assign reclaim_off = reclaim_data - BASE_ADDR;
  assign reclaim_ok  = ((reclaim_off & LINE_MASK) == 32'd0) &&
                       ((reclaim_off >> STRIDE_LOG2) < 32'(NUM_CHUNKS));
  assign init_addr   = BASE_ADDR + (32'(init_idx) << STRIDE_LOG2);

  always_comb begin
    state_next    = state;
    alloc_valid   = 1'b0;
    reclaim_ready = 1'b0;
    init_busy     = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (init_idx == LAST_IDX) state_next = ST_RUN;
      end
      ST_RUN: begin
        alloc_valid   = (count != '0);
        reclaim_ready = (count < NUM_C);
        if (flushReq) state_next = ST_FLUSH_ACK;
      end
      ST_FLUSH_ACK:  state_next = ST_FLUSH_WAIT;
      ST_FLUSH_WAIT: if (flushDone) state_next = ST_INIT;
      default:       state_next = ST_INIT;
    endcase
  end

  assign alloc_fire   = alloc_valid & alloc_ready;
  assign reclaim_fire = reclaim_valid & reclaim_ready;
  // INIT and valid reclaims share the single write port; they never overlap.
  assign store        = (state == ST_INIT) | (reclaim_fire & reclaim_ok);
  assign wr_data      = (state == ST_INIT) ? init_addr : reclaim_data;

  always_ff @(posedge ACLK) begin
    if (store) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  assign alloc_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign free_count = count;
  assign fsm_state  = state;

  always_ff @(posedge ACLK or negedge Axi_resetn) begin
    if (!Axi_resetn) state <= ST_INIT;
    else             state <= state_next;
  end

  always_ff @(posedge ACLK or negedge Axi_resetn) begin
    if (!Axi_resetn) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      init_idx    <= '0;
      reclaim_err <= 1'b0;
      flushAck    <= 1'b0;
    end else begin
      reclaim_err <= reclaim_fire & ~reclaim_ok;
      flushAck    <= (state == ST_RUN) & flushReq;
      if (store)              wr_ptr   <= wr_ptr + 1'b1;
      if (alloc_fire)         rd_ptr   <= rd_ptr + 1'b1;
      if (state == ST_INIT)   init_idx <= init_idx + 1'b1;
      case ({store, alloc_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == ST_FLUSH_WAIT && flushDone) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        init_idx <= '0;
      end
    end
  end

`ifdef MEM_ALLOC_POOL_STATS_EN
  logic [31:0] alloc_cnt, reclaim_cnt;

  // Flushes deliberately leave these alone; only reset clears them.
  always_ff @(posedge ACLK or negedge Axi_resetn) begin
    if (!Axi_resetn) begin
      alloc_cnt   <= '0;
      reclaim_cnt <= '0;
    end else begin
      if (alloc_fire)   alloc_cnt   <= alloc_cnt + 32'd1;
      if (reclaim_fire) reclaim_cnt <= reclaim_cnt + 32'd1;
    end
  end

  assign stats_alloc   = alloc_cnt;
  assign stats_reclaim = reclaim_cnt;
`else
  assign stats_alloc   = 32'h0;
  assign stats_reclaim = 32'h0;
`endif

endmodule
